// File: rtl/block_dispatch.sv
// Kernel block dispatcher: hands block ids to NUM_CORES WaveDispatch units and tracks completion.
// Optional BLOCK_DISPATCH_PERF_EN adds a saturating busy_cycles counter for DISPATCH time.
module block_dispatch #(
  parameter int NUM_CORES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             num_threads,
  input  logic [31:0]             block_dim,
  input  logic [NUM_CORES-1:0]    core_block_done,
  output logic [NUM_CORES*32-1:0] core_block_id,
  output logic [NUM_CORES-1:0]    core_rst,
  output logic [NUM_CORES-1:0]    core_enable,
  output logic                    done
`ifdef BLOCK_DISPATCH_PERF_EN
  ,
  output logic [31:0]             busy_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    C_FREE,
    C_RESET,
    C_RUN
  } core_state_t;

  state_t                        state_q, state_d;
  core_state_t                   cst_q [NUM_CORES];
  core_state_t                   cst_d [NUM_CORES];
  logic [NUM_CORES-1:0][31:0]    id_q, id_d;
  logic [NUM_CORES-1:0]          crst_q, crst_d;
  logic [NUM_CORES-1:0]          en_q, en_d;
  logic                          done_q, done_d;
  logic [31:0]                   nt_q, nt_d;
  logic [31:0]                   bd_q, bd_d;
  logic [31:0]                   disp_q, disp_d;
  logic [31:0]                   fin_q, fin_d;
  logic [31:0]                   num_blocks;
  logic [31:0]                   next_id;
  logic [31:0]                   fin_cnt;

  // Ceiling divide without the (a+b-1) form, so large thread counts cannot wrap.
  always_comb begin
    num_blocks = '0;
    if (bd_q != '0 && nt_q != '0) begin
      num_blocks = nt_q / bd_q;
      if ((nt_q % bd_q) != '0) num_blocks = num_blocks + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      for (int unsigned i = 0; i < NUM_CORES; i++) cst_q[i] <= C_FREE;
      id_q    <= '1;
      crst_q  <= '1;
      en_q    <= '0;
      done_q  <= 1'b0;
      nt_q    <= '0;
      bd_q    <= '0;
      disp_q  <= '0;
      fin_q   <= '0;
    end else begin
      state_q <= state_d;
      cst_q   <= cst_d;
      id_q    <= id_d;
      crst_q  <= crst_d;
      en_q    <= en_d;
      done_q  <= done_d;
      nt_q    <= nt_d;
      bd_q    <= bd_d;
      disp_q  <= disp_d;
      fin_q   <= fin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cst_d   = cst_q;
    id_d    = id_q;
    crst_d  = '0;
    en_d    = en_q;
    done_d  = done_q;
    nt_d    = nt_q;
    bd_d    = bd_q;
    disp_d  = disp_q;
    fin_d   = fin_q;
    next_id = disp_q;
    fin_cnt = '0;

    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          nt_d    = num_threads;
          bd_d    = block_dim;
          disp_d  = '0;
          fin_d   = '0;
          state_d = S_DISPATCH;
        end
      end

      S_DISPATCH: begin
        // Decisions use only the pre-edge core state, so a core freed here waits a cycle.
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
          case (cst_q[i])
            C_RESET: begin
              cst_d[i] = C_RUN;
              en_d[i]  = 1'b1;
            end
            C_RUN: begin
              if (core_block_done[i]) begin
                cst_d[i] = C_FREE;
                en_d[i]  = 1'b0;
                id_d[i]  = '1;
                fin_cnt  = fin_cnt + 32'd1;
              end
            end
            default: begin
              if (fin_q != num_blocks && next_id < num_blocks) begin
                cst_d[i]  = C_RESET;
                id_d[i]   = next_id;
                crst_d[i] = 1'b1;
                next_id   = next_id + 32'd1;
              end
            end
          endcase
        end
        disp_d = next_id;
        fin_d  = fin_q + fin_cnt;
        if (fin_q == num_blocks) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          en_d    = '0;
        end
      end

      S_DONE: begin
        en_d = '0;
        if (!start) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign core_block_id = id_q;
  assign core_rst      = crst_q;
  assign core_enable   = en_q;
  assign done          = done_q;

`ifdef BLOCK_DISPATCH_PERF_EN
  logic [31:0] busy_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      busy_q <= '0;
    end else if (state_q == S_DISPATCH && busy_q != '1) begin
      busy_q <= busy_q + 32'd1;
    end
  end

  assign busy_cycles = busy_q;
`endif

endmodule
